gain_stage: RTL and testbench

Volume/gain stage directly downstream of the de-emphasis IIR in the FM radio audio path. It pops de-emphasised samples from a first-word-fall-through input FIFO, multiplies each by a programmable Q-format volume, dequantizes, rescales to the 14-bit audio output format, and pushes the result into an output FIFO. It uses a two-stage stall-able pipeline, and its output is bit-exact with the software golden model's gain function.

---
 rtl/gain_stage_pkg.sv | 25 ++
 rtl/gain_stage.sv | 86 ++++++++
 tb/tb_gain_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/gain_stage_pkg.sv
// Shared radio fixed-point helpers: sample width, Q-format fraction bits and
// the quantize/dequantize primitives used by the IIR, gain and later stages.
package gain_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BITS       = 10;
  // Fraction bits of the 14-bit audio output format.
  localparam int OUT_FRAC   = 14;

  // Scale an integer up into Q-bits format.
  function automatic logic signed [63:0] QUANTIZE(input logic signed [63:0] v,
                                                  input int               bits);
    return v <<< bits;
  endfunction

  // Signed divide by 2^bits, truncating toward zero. Negative values get a
  // bias of 2^bits-1 so the arithmetic shift does not round toward -inf.
  function automatic logic signed [63:0] DEQUANTIZE(input logic signed [63:0] v,
                                                    input int               bits);
    logic signed [63:0] bias;
    bias = (v < 0) ? ((64'sd1 <<< bits) - 64'sd1) : 64'sd0;
    return (v + bias) >>> bits;
  endfunction

endpackage

// File: rtl/gain_stage.sv
// Volume/gain stage after the de-emphasis IIR. Pops FWFT input samples,
// multiplies by a Q-BITS volume, dequantizes, rescales to the 14-bit audio
// format (wrapping, not saturating) and pushes into the output FIFO through a
// two-stage pipeline that stalls as a whole when the output FIFO is full.
// DATA_WIDTH up to 32 is supported (the product must fit in 64 bits).
module gain_stage
  import gain_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = gain_stage_pkg::DATA_WIDTH,
  parameter int BITS         = gain_stage_pkg::BITS,
  parameter int VOLUME_RESET = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  volume_wr,
  input  logic [DATA_WIDTH-1:0] volume_in,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_wr_en
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] volume;
  logic signed [PROD_W-1:0]     prod_p0;
  logic signed [PROD_W-1:0]     prod_p1;
  logic signed [DATA_WIDTH-1:0] data_p2;
  logic                         vld_p1;
  logic                         vld_p2;
  logic                         advance;

  // Dequantize the product, move it to the output fraction position and keep
  // the low DATA_WIDTH bits (wraps on overflow, matching the golden model).
  function automatic logic signed [DATA_WIDTH-1:0] rescale(input logic signed [PROD_W-1:0] p);
    logic signed [63:0] dq;
    logic signed [63:0] sh;
    dq = DEQUANTIZE(64'(p), BITS);
    sh = dq <<< (OUT_FRAC - BITS);
    return sh[DATA_WIDTH-1:0];
  endfunction

  // The whole pipeline moves unless a valid s2 sample is blocked by a full FIFO.
  assign advance   = !(vld_p2 && out_full);
  assign in_rd_en  = !in_empty && advance;
  assign out_wr_en = vld_p2 && !out_full;
  assign out_din   = data_p2;

  // Stage 0: the popped sample is paired with the volume held before any
  // same-cycle write lands.
  assign prod_p0 = PROD_W'($signed(in_dout)) * PROD_W'(volume);

  // Volume register; a write takes effect for pops on later cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      volume <= DATA_WIDTH'(VOLUME_RESET);
    end else if (volume_wr) begin
      volume <= volume_in;
    end
  end

  // Valid bits travel with the data; bubbles enter s1 when nothing is popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= in_rd_en;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1 -> stage 2 data; cleared on reset so out_din reads zero afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_p1 <= '0;
      data_p2 <= '0;
    end else if (advance) begin
      if (in_rd_en) prod_p1 <= prod_p0;
      if (vld_p1)   data_p2 <= rescale(prod_p1);
    end
  end

endmodule

// File: tb/tb_gain_stage.sv
// Bench for gain_stage: FWFT input FIFO model, random and directed stimulus,
// scoreboard of expected outputs checked by an independent monitor.
module tb_gain_stage;

  localparam int BITS = 10;
  localparam int VRST = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        volume_wr = 1'b0;
  logic [31:0] volume_in = '0;
  logic        in_empty = 1'b1;
  logic [31:0] in_dout = '0;
  logic        in_rd_en;
  logic        out_full = 1'b0;
  logic [31:0] out_din;
  logic        out_wr_en;

  int total = 0;
  int bad   = 0;
  int outs  = 0;
  int pops  = 0;

  logic [31:0]        in_fifo[$];
  logic [31:0]        exp_q[$];
  logic signed [31:0] model_vol = VRST;

  bit          popped;
  bit          saw_wr;
  logic [31:0] seen_din;

  always #5 clock = ~clock;

  gain_stage #(
    .DATA_WIDTH  (32),
    .BITS        (BITS),
    .VOLUME_RESET(VRST)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .volume_wr(volume_wr),
    .volume_in(volume_in),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .in_rd_en (in_rd_en),
    .out_full (out_full),
    .out_din  (out_din),
    .out_wr_en(out_wr_en)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact product, integer division toward zero, scale to Q14, wrap.
  function automatic logic [31:0] model(input logic signed [31:0] x,
                                        input logic signed [31:0] v);
    longint p, q, r;
    p = longint'(x) * longint'(v);
    q = p / (longint'(1) << BITS);
    r = q * (longint'(1) << (14 - BITS));
    return r[31:0];
  endfunction

  // Monitor: every push into the output FIFO must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && out_wr_en) begin
      chk("push_while_full", {31'b0, out_full}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_push: got %h expected none", out_din);
      end else begin
        chk("out_din", out_din, exp_q.pop_front());
      end
      outs++;
    end
  end

  task automatic refresh();
    in_empty = (in_fifo.size() == 0);
    in_dout  = in_empty ? 32'h0 : in_fifo[0];
  endtask

  task automatic push(input logic [31:0] x);
    in_fifo.push_back(x);
    refresh();
  endtask

  // One clock: observe what the DUT will do at the coming edge, then let the
  // FIFO model react after the edge.
  task automatic cyc();
    @(negedge clock);
    popped   = in_rd_en;
    saw_wr   = out_wr_en;
    seen_din = out_din;
    if (reset) begin
      exp_q.delete();
      model_vol = VRST;
    end else begin
      if (in_rd_en) begin
        if (in_empty) begin
          total++;
          bad++;
          $display("FAIL pop_when_empty: got rd_en=1 expected 0");
        end
        exp_q.push_back(model(in_dout, model_vol));
        pops++;
      end
      if (volume_wr) model_vol = volume_in;
    end
    @(posedge clock);
    #1;
    if (popped && in_fifo.size() > 0) void'(in_fifo.pop_front());
    refresh();
  endtask

  // Single sample through an otherwise empty pipeline; checks latency and value.
  task automatic directed(input string nm, input logic [31:0] x, input logic [31:0] exp);
    int k;
    push(x);
    cyc();
    chk({nm, "_pop"}, {31'b0, popped}, 32'd1);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!saw_wr && k < 10);
    chk({nm, "_latency"}, k, 2);
    chk({nm, "_value"}, seen_din, exp);
  endtask

  task automatic drain(input string nm);
    int k;
    out_full = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || in_fifo.size() != 0) && k < 400) begin
      cyc();
      k++;
    end
    chk({nm, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, base, pc;
    logic [31:0] d0;

    // Reset state
    repeat (3) cyc();
    chk("rst_wr_en", {31'b0, out_wr_en}, 32'd0);
    chk("rst_din", out_din, 32'h0);
    chk("rst_rd_en", {31'b0, in_rd_en}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_rd_en", {31'b0, in_rd_en}, 32'd0);
    chk("idle_wr_en", {31'b0, out_wr_en}, 32'd0);

    // Directed vectors
    directed("one", 32'h0000_0400, 32'h0000_4000);
    directed("neg1", 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    volume_wr = 1'b1;
    volume_in = 32'd1;
    cyc();
    volume_wr = 1'b0;
    directed("trunc", 32'hFFFF_FFFF, 32'h0000_0000);

    // Back-to-back stream of 100 audio-range samples at volume 1.5
    volume_wr = 1'b1;
    volume_in = 32'd1536;
    cyc();
    volume_wr = 1'b0;
    for (int i = 0; i < 100; i++) push(32'($urandom_range(0, 65535)) - 32'd32768);
    base = outs;
    n = 0;
    while (outs < base + 100 && n < 400) begin
      cyc();
      n++;
    end
    chk("stream_cycles", n, 102);
    chk("stream_count", outs - base, 100);

    // Output stall mid-stream
    for (int i = 0; i < 40; i++) push($urandom_range(0, 200000) - 100000);
    repeat (10) cyc();
    out_full = 1'b1;
    cyc();
    d0 = seen_din;
    pc = popped;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pc += popped;
      chk("stall_stable", seen_din, d0);
    end
    chk("stall_pops_le2", {31'b0, pc <= 2}, 32'd1);
    drain("stall");

    // Randomised traffic with volume changes and backpressure
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7)
        push($urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 65535)) - 32'd32768);
      out_full  = ($urandom_range(0, 9) < 3);
      volume_wr = ($urandom_range(0, 19) == 0);
      volume_in = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4096)) - 32'd2048;
      cyc();
    end
    volume_wr = 1'b0;
    drain("random");

    // Reset with two samples in flight
    volume_wr = 1'b1;
    volume_in = 32'd2048;
    cyc();
    volume_wr = 1'b0;
    out_full = 1'b1;
    push(32'd123);
    push(32'd456);
    repeat (4) cyc();
    chk("inflight_popped", in_fifo.size(), 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    out_full = 1'b0;
    cyc();
    chk("post_rst_wr_en", {31'b0, saw_wr}, 32'd0);
    chk("post_rst_din", seen_din, 32'h0);
    directed("post_rst", 32'h0000_0400, 32'h0000_4000);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
